// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester, consumer and external 4-bit adder signals of nibble_serial_adder_ctrl.
interface nibble_serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             ready;
   logic             op_sub;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry_in;
   logic [3:0]       adder_a;
   logic [3:0]       adder_b;
   logic             adder_cin;
   logic [3:0]       adder_sum;
   logic             adder_cout;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             ovf;
   logic             result_valid;
   logic             result_ready;

   modport slave (
      input  start, op_sub, opa, opb, carry_in, adder_sum, adder_cout, result_ready,
      output ready, adder_a, adder_b, adder_cin, result, carry_out, ovf, result_valid
   );

   modport master (
      output start, op_sub, opa, opb, carry_in, adder_sum, adder_cout, result_ready,
      input  ready, adder_a, adder_b, adder_cin, result, carry_out, ovf, result_valid
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per cycle through an external 4-bit adder.
// Define NIBBLE_ADDER_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module nibble_serial_adder_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   nibble_serial_adder_ctrl_if.slave  bus
);
   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned K_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

   if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [K_W-1:0]   k;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             carry_out_q;
   logic             valid_q;
   logic             ready_q;

   // Operand registers shift right each nibble, so their low nibble feeds the adder
   // and they drain to zero, leaving the adder ports at 0 outside RUN.
   assign bus.adder_a      = a_sh[3:0];
   assign bus.adder_b      = b_sh[3:0];
   assign bus.adder_cin    = carry_q;
   assign bus.result       = result_q;
   assign bus.carry_out    = carry_out_q;
   assign bus.result_valid = valid_q;
   assign bus.ready        = ready_q;

`ifdef NIBBLE_ADDER_OVF_EN
   logic ovf_q;
   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         k           <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         valid_q     <= 1'b0;
         ready_q     <= 1'b1;
`ifdef NIBBLE_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh        <= bus.opa;
                  b_sh        <= bus.op_sub ? ~bus.opb : bus.opb;
                  carry_q     <= bus.op_sub ? 1'b1 : bus.carry_in;
                  k           <= '0;
                  result_q    <= '0;
                  carry_out_q <= 1'b0;
                  ready_q     <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
                  ovf_q       <= 1'b0;
`endif
                  state       <= RUN;
               end
            end
            RUN: begin
               result_q[4*k +: 4] <= bus.adder_sum;
               a_sh               <= a_sh >> 4;
               b_sh               <= b_sh >> 4;
               if (k == K_LAST) begin
                  carry_q     <= 1'b0;
                  carry_out_q <= bus.adder_cout;
                  valid_q     <= 1'b1;
`ifdef NIBBLE_ADDER_OVF_EN
                  // On the last nibble the low nibbles hold the operand sign bits.
                  ovf_q       <= (a_sh[3] == b_sh[3]) && (bus.adder_sum[3] != a_sh[3]);
`endif
                  state       <= DONE;
               end else begin
                  carry_q <= bus.adder_cout;
                  k       <= k + K_W'(1);
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16) with a behavioural 4-bit adder.
module tb_nibble_serial_adder_ctrl;
   localparam int unsigned WIDTH = 16;
`ifdef NIBBLE_ADDER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] res;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign {bus.adder_cout, bus.adder_sum} =
      5'(bus.adder_a) + 5'(bus.adder_b) + 5'(bus.adder_cin);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every consumer handshake pops one expected entry.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'(bus.result_valid), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result",    32'(bus.result),    32'(e.res));
            chk("carry_out", 32'(bus.carry_out), 32'(e.co));
            chk("ovf",       32'(bus.ovf),       32'(e.ov));
         end
      end
   end

   task automatic do_op(input logic sub, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] er, input logic eco,
                        input logic eov, input logic [3:0] ecin, input bit hold);
      logic [3:0] got_cin;
      exp_t e;
      @(negedge clk);
      chk("ready_idle", 32'(bus.ready), 32'(1));
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.op_sub       = sub;
      bus.opa          = a;
      bus.opb          = b;
      bus.carry_in     = ci;
      bus.result_ready = !hold;
      e.res = er; e.co = eco; e.ov = eov & OVF_ON;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("run_ready", 32'(bus.ready), 32'(0));
         chk("run_valid", 32'(bus.result_valid), 32'(0));
         got_cin[i] = bus.adder_cin;
      end
      chk("cin_seq", 32'(got_cin), 32'(ecin));
      @(negedge clk);
      chk("valid_latency", 32'(bus.result_valid), 32'(1));
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.opa   = 16'hAAAA + 16'(i);
            bus.opb   = 16'h5555;
            @(negedge clk);
            chk("hold_valid",  32'(bus.result_valid), 32'(1));
            chk("hold_result", 32'(bus.result), 32'(er));
            chk("hold_ready",  32'(bus.ready), 32'(0));
         end
         @(posedge clk); #1;
         bus.result_ready = 1'b1;
         @(negedge clk);
         @(posedge clk); #1;
         bus.start = 1'b0;
         @(negedge clk);
         chk("post_hs_valid",  32'(bus.result_valid), 32'(0));
         chk("post_hs_ready",  32'(bus.ready), 32'(1));
         chk("post_hs_result", 32'(bus.result), 32'(er));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.op_sub       = 1'b0;
      bus.opa          = '0;
      bus.opb          = '0;
      bus.carry_in     = 1'b0;
      bus.result_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready",  32'(bus.ready), 32'(1));
      chk("rst_valid",  32'(bus.result_valid), 32'(0));
      chk("rst_result", 32'(bus.result), 32'(0));
      chk("rst_cout",   32'(bus.carry_out), 32'(0));
      chk("rst_ovf",    32'(bus.ovf), 32'(0));
      chk("rst_adder",  32'({bus.adder_a, bus.adder_b, bus.adder_cin}), 32'(0));

      //    sub   opa       opb       cin   result    co    ov    cin seq  hold
      do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 1'b0);
      do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 1'b0);
      do_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 1'b0);
      do_op(1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0, 4'b1111, 1'b0);
      do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 1'b0);
      do_op(1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, 4'b0001, 1'b0);
      do_op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 1'b0);

      // Reset in the second RUN cycle of an operation that never completes.
      @(negedge clk);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op_sub = 1'b0;
      bus.opa = 16'h1234;
      bus.opb = 16'h1111;
      bus.carry_in = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("midrun_ready",  32'(bus.ready), 32'(1));
      chk("midrun_valid",  32'(bus.result_valid), 32'(0));
      chk("midrun_result", 32'(bus.result), 32'(0));
      chk("midrun_cout",   32'(bus.carry_out), 32'(0));
      chk("midrun_adder",  32'({bus.adder_a, bus.adder_b, bus.adder_cin}), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0110, 1'b0);
      do_op(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 4'b0000, 1'b1);
      do_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110, 1'b0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drain", 32'(sb.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit add/subtract by time-sharing one external 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Drives the adder's in_a/in_b/carry_in and samples its out/carry_out combinationally on the same cycle.
- Registers the carry between nibbles and assembles the WIDTH-bit result.
- Sits between a requester (start/ready handshake) and a consumer (valid/ready handshake).

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration $error otherwise).
- NIBBLES, WIDTH/4, number of adder passes (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- ready  output  1  controller idle, can accept start.
- op_sub  input  1  0 = A+B+carry_in; 1 = A-B (computed as A+~B+1, carry_in ignored).
- opa  input  WIDTH  operand A, sampled on accept.
- opb  input  WIDTH  operand B, sampled on accept.
- carry_in  input  1  initial carry for add, sampled on accept.
- adder_a  output  4  to adder in_a.
- adder_b  output  4  to adder in_b.
- adder_cin  output  1  to adder carry_in.
- adder_sum  input  4  from adder out.
- adder_cout  input  1  from adder carry_out.
- result  output  WIDTH  assembled sum/difference.
- carry_out  output  1  final carry (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow (see Optional Feature).
- result_valid  output  1  result/carry_out/ovf valid.
- result_ready  input  1  consumer accepts result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, result=0, carry_out=0, ovf=0, result_valid=0, nibble counter=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: ready=1; adder_a/adder_b/adder_cin driven 0.
  - start=1 at edge T: latch opa, opb_eff (~opb if op_sub, else opb), and cin_eff (1 if op_sub, else carry_in).
  - Clear counter k=0 and result register; go to RUN.
- RUN (ready=0), nibble k:
  - Drive adder_a = opa_reg[4k+3:4k], adder_b = opb_eff_reg[4k+3:4k].
  - adder_cin = cin_eff when k=0, else the carry register.
  - At each edge: result[4k+3:4k] <= adder_sum, carry register <= adder_cout, k <= k+1.
  - When k=NIBBLES-1, go to DONE at that edge instead of incrementing k.
- DONE:
  - result_valid=1; carry_out=last adder_cout; adder ports driven 0.
  - Outputs held stable while result_ready=0.
  - result_ready=1 at an edge: go to IDLE, result_valid deasserts. result/carry_out hold their values until the next accept.
- Latency: start accepted at edge T; RUN occupies cycles T..T+NIBBLES-1; result_valid=1 from edge T+NIBBLES. For WIDTH=16, that is 4 cycles.
- Throughput: at most one operation per NIBBLES+2 cycles.
- start while ready=0 is ignored (not queued).
- start during DONE: ignored, even in the same cycle as result_ready=1. ready rises the cycle after the handshake.
- Arithmetic: modulo 2^WIDTH; carry_out is the true carry of bit WIDTH-1.
- Adder path is combinational; the controller adds no register between adder_sum and the result capture.

Optional Feature:
- Macro: NIBBLE_ADDER_OVF_EN.
- Defined: on the last nibble, ovf is registered as (opa[MSB]==opb_eff[MSB]) && (adder_sum[3]!=opa[MSB]). It is valid with result_valid and holds like result.
- Not defined: the ovf port still exists and is tied to constant 0. No extra logic.

Test Plan:
- WIDTH=16, add 0x1234+0x4321, carry_in=0 -> result 0x5555, carry_out 0; result_valid exactly 4 edges after accept; ready=0 throughout.
- Add 0xFFFF+0x0001, carry_in=0 -> result 0x0000, carry_out 1; per-cycle adder_cin sequence 0,1,1,1 (carry propagates through the register on every nibble).
- Subtract (op_sub=1) 0x0005-0x0007, carry_in=1 (ignored) -> result 0xFFFE, carry_out 0, ovf 0. Then 0x0007-0x0005 -> 0x0002, carry_out 1.
- Add 0x7FFF+0x0001 -> result 0x8000, carry_out 0; ovf=1 with NIBBLE_ADDER_OVF_EN, ovf=0 without.
- Assert reset during the 2nd RUN cycle -> all outputs 0 immediately, ready=1; next op 0x00FF+0x0001 -> 0x0100 correct.
- Hold result_ready=0 for 10 cycles with start pulsed -> result stable, start ignored. result_ready=1 -> result_valid falls next edge, ready=1, new start accepted.
